mem_sequencer: RTL and testbench

MEM_SEQUENCER -- requirements
Module: mem_sequencer

---
 rtl/mem_sequencer.sv | 139 +++++++++++++
 tb/tb_mem_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_sequencer.sv
// mem_sequencer: fetch / execute / data-memory / writeback sequencer
// with ack timeouts, interrupt entry and a trap strobe.
module mem_sequencer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ACKI_n,
  input  logic       ACKD_n,
  input  logic [2:0] OINT_n,
  input  logic       mem_read,
  input  logic       mem_write,
  input  logic       reg_write,
  input  logic [1:0] inst_size,
  input  logic       int_en,
  output logic       fetch_req,
  output logic       ir_we,
  output logic       MREQ,
  output logic       WRITE,
  output logic [1:0] SIZE,
  output logic       pc_we,
  output logic       reg_we,
  output logic       IACK_n,
  output logic       trap,
  output logic [2:0] trap_cause,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC  = 3'd1,
    S_DMEM  = 3'd2,
    S_WB    = 3'd3,
    S_INTR  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t     st;
  logic [7:0] wait_cnt;
  logic       lat_write;
  logic       lat_reg_write;
  logic [1:0] lat_size;
  logic [2:0] cause_q;

  logic timeout;
  logic mem_op;
  logic irq_req;

  assign timeout = (wait_cnt == TO_LAST);
  assign mem_op  = mem_read | mem_write;
  assign irq_req = int_en && (OINT_n != 3'b111);

  // State, wait counter, decoded-control latches and trap cause.
  // Write wins over read, so only the write bit needs latching.
  always_ff @(posedge clk) begin
    if (!rst) begin
      st            <= S_FETCH;
      wait_cnt      <= 8'd0;
      lat_write     <= 1'b0;
      lat_reg_write <= 1'b0;
      lat_size      <= 2'b00;
      cause_q       <= 3'b000;
    end else begin
      unique case (st)
        S_FETCH: begin
          if (!ACKI_n) begin
            st       <= S_EXEC;
            wait_cnt <= 8'd0;
          end else if (timeout) begin
            st       <= S_ERR;
            cause_q  <= 3'b001;
            wait_cnt <= 8'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_EXEC: begin
          lat_write     <= mem_write;
          lat_reg_write <= reg_write;
          lat_size      <= inst_size;
          wait_cnt      <= 8'd0;
          if (mem_op && inst_size == 2'b11) begin
            st      <= S_ERR;
            cause_q <= 3'b011;
          end else if (mem_op) begin
            st <= S_DMEM;
          end else begin
            st <= S_WB;
          end
        end
        S_DMEM: begin
          if (!ACKD_n) begin
            st       <= S_WB;
            wait_cnt <= 8'd0;
          end else if (timeout) begin
            st       <= S_ERR;
            cause_q  <= 3'b010;
            wait_cnt <= 8'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_WB: begin
          wait_cnt <= 8'd0;
          if (irq_req) begin
            st      <= S_INTR;
            cause_q <= {1'b1, ~OINT_n[1:0]};
          end else begin
            st <= S_FETCH;
          end
        end
        S_INTR, S_ERR: begin
          st       <= S_FETCH;
          wait_cnt <= 8'd0;
        end
        default: begin
          st       <= S_FETCH;
          wait_cnt <= 8'd0;
        end
      endcase
    end
  end

  // Outputs decode from registered state and latches only.
  assign fetch_req  = (st == S_FETCH);
  assign ir_we      = (st == S_EXEC);
  assign MREQ       = (st == S_DMEM);
  assign WRITE      = MREQ & lat_write;
  assign SIZE       = MREQ ? lat_size : 2'b00;
  assign pc_we      = (st == S_WB) | (st == S_ERR);
  assign reg_we     = (st == S_WB) & lat_reg_write;
  assign IACK_n     = (st != S_INTR);
  assign trap       = (st == S_INTR) | (st == S_ERR);
  assign trap_cause = cause_q;
  assign state      = st;

endmodule

// File: tb/tb_mem_sequencer.sv
// tb_mem_sequencer: random instruction stream expanded into an
// expected per-cycle trace, plus a mid-DMEM reset check.
module tb_mem_sequencer;

  localparam int TO = 16;

  typedef struct packed {
    logic       acki_n;
    logic       ackd_n;
    logic [2:0] oint_n;
    logic       mr;
    logic       mw;
    logic       rw;
    logic [1:0] sz;
    logic       ie;
  } stim_t;

  typedef struct packed {
    logic [2:0] st;
    logic       fr;
    logic       irw;
    logic       mreq;
    logic       wr;
    logic [1:0] size;
    logic       pcw;
    logic       rgw;
    logic       iack_n;
    logic       trap;
    logic [2:0] cause;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       ACKI_n, ACKD_n;
  logic [2:0] OINT_n;
  logic       mem_read, mem_write, reg_write;
  logic [1:0] inst_size;
  logic       int_en;
  logic       fetch_req, ir_we, MREQ, WRITE;
  logic [1:0] SIZE;
  logic       pc_we, reg_we, IACK_n, trap;
  logic [2:0] trap_cause, state;

  int checks = 0;
  int errors = 0;

  stim_t      sq[$];
  exp_t       eq[$];
  logic [2:0] cur_cause;

  always #5 clk = ~clk;

  mem_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ACKI_n(ACKI_n), .ACKD_n(ACKD_n),
    .OINT_n(OINT_n),
    .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .inst_size(inst_size),
    .int_en(int_en),
    .fetch_req(fetch_req), .ir_we(ir_we),
    .MREQ(MREQ), .WRITE(WRITE), .SIZE(SIZE),
    .pc_we(pc_we), .reg_we(reg_we),
    .IACK_n(IACK_n), .trap(trap),
    .trap_cause(trap_cause), .state(state)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t",
               tag, got, want, $time);
    end
  endtask

  function automatic exp_t observed();
    exp_t o;
    o.st     = state;
    o.fr     = fetch_req;
    o.irw    = ir_we;
    o.mreq   = MREQ;
    o.wr     = WRITE;
    o.size   = SIZE;
    o.pcw    = pc_we;
    o.rgw    = reg_we;
    o.iack_n = IACK_n;
    o.trap   = trap;
    o.cause  = trap_cause;
    return o;
  endfunction

  // Quiet cycle in a given phase; callers add that phase's strobes.
  function automatic exp_t base(input logic [2:0] st);
    exp_t e;
    e        = '0;
    e.st     = st;
    e.iack_n = 1'b1;
    e.cause  = cur_cause;
    return e;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s = stim_t'($urandom);
    return s;
  endfunction

  function automatic int pick_lat();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return 1;
      2: return TO - 2;
      3: return TO - 1;
      4: return TO;
      default: return $urandom_range(0, TO + 3);
    endcase
  endfunction

  task automatic push(input stim_t s, input exp_t e);
    sq.push_back(s);
    eq.push_back(e);
  endtask

  task automatic push_err(input logic [2:0] c);
    exp_t e;
    cur_cause = c;
    e = base(3'd5);
    e.trap = 1'b1;
    e.pcw  = 1'b1;
    push(rnd(), e);
  endtask

  // One instruction: ack latencies count cycles waited before the
  // acknowledge; waits of TO or more end in an error trap.
  task automatic gen_instr();
    int fl, dl;
    logic mr, mw, rw, ie;
    logic [1:0] sz;
    logic [2:0] oi;
    stim_t s;
    exp_t  e;
    fl = pick_lat();
    mr = 1'($urandom); mw = 1'($urandom); rw = 1'($urandom);
    sz = 2'($urandom); ie = 1'($urandom);
    oi = ($urandom_range(0, 2) == 0) ? 3'b111 : 3'($urandom);
    e = base(3'd0);
    e.fr = 1'b1;
    if (fl >= TO) begin
      for (int c = 0; c < TO; c++) begin
        s = rnd(); s.acki_n = 1'b1; push(s, e);
      end
      push_err(3'b001);
      return;
    end
    for (int c = 0; c < fl; c++) begin
      s = rnd(); s.acki_n = 1'b1; push(s, e);
    end
    s = rnd(); s.acki_n = 1'b0; push(s, e);
    e = base(3'd1);
    e.irw = 1'b1;
    s = rnd();
    s.mr = mr; s.mw = mw; s.rw = rw; s.sz = sz;
    push(s, e);
    if ((mr | mw) && sz == 2'b11) begin
      push_err(3'b011);
      return;
    end
    if (mr | mw) begin
      dl = pick_lat();
      e = base(3'd2);
      e.mreq = 1'b1;
      e.wr   = mw;
      e.size = sz;
      if (dl >= TO) begin
        for (int c = 0; c < TO; c++) begin
          s = rnd(); s.ackd_n = 1'b1; push(s, e);
        end
        push_err(3'b010);
        return;
      end
      for (int c = 0; c < dl; c++) begin
        s = rnd(); s.ackd_n = 1'b1; push(s, e);
      end
      s = rnd(); s.ackd_n = 1'b0; push(s, e);
    end
    e = base(3'd3);
    e.pcw = 1'b1;
    e.rgw = rw;
    s = rnd();
    s.ie = ie; s.oint_n = oi;
    push(s, e);
    if (ie && oi != 3'b111) begin
      cur_cause = {1'b1, ~oi[1:0]};
      e = base(3'd4);
      e.iack_n = 1'b0;
      e.trap   = 1'b1;
      push(rnd(), e);
    end
  endtask

  task automatic apply(input stim_t s);
    ACKI_n    = s.acki_n;
    ACKD_n    = s.ackd_n;
    OINT_n    = s.oint_n;
    mem_read  = s.mr;
    mem_write = s.mw;
    reg_write = s.rw;
    inst_size = s.sz;
    int_en    = s.ie;
  endtask

  initial begin
    stim_t s;
    exp_t  e;
    cur_cause = 3'b000;
    rst = 1'b0;
    apply(rnd());
    repeat (2) @(negedge clk);
    e = base(3'd0);
    e.fr = 1'b1;
    chk("reset", 32'(observed()), 32'(e));

    for (int i = 0; i < 300; i++) gen_instr();
    for (int i = 0; i < sq.size(); i++) begin
      @(negedge clk);
      chk("trace", 32'(observed()), 32'(eq[i]));
      rst = 1'b1;
      apply(sq[i]);
    end

    // Reset during a data phase with the ack still pending.
    @(negedge clk);
    e = base(3'd0);
    e.fr = 1'b1;
    chk("idle_fetch", 32'(observed()), 32'(e));
    s = rnd(); s.acki_n = 1'b0; apply(s);
    @(negedge clk);
    s = rnd();
    s.mr = 1'b1; s.mw = 1'b0; s.rw = 1'b1; s.sz = 2'b10;
    s.acki_n = 1'b1; s.ackd_n = 1'b1;
    apply(s);
    @(negedge clk);
    e = base(3'd2);
    e.mreq = 1'b1;
    e.size = 2'b10;
    chk("dmem_pre_rst", 32'(observed()), 32'(e));
    s = rnd(); s.ackd_n = 1'b1; apply(s);
    rst = 1'b0;
    @(negedge clk);
    cur_cause = 3'b000;
    e = base(3'd0);
    e.fr = 1'b1;
    chk("dmem_rst", 32'(observed()), 32'(e));
    rst = 1'b1;
    s = rnd(); s.acki_n = 1'b1; apply(s);
    @(negedge clk);
    chk("post_rst", 32'(observed()), 32'(e));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
